fetch: RTL and testbench



---
 rtl/fetch_if.sv | 32 +++
 rtl/fetch.sv | 108 ++++++++++
 tb/tb_fetch.sv | 137 +++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// fetch_if: instruction-memory, dispatch-control, BTB-training and output-register signals of the fetch stage
interface fetch_if;
    logic        imem_ren;
    logic [31:0] imem_addr;
    logic        imem_hit;
    logic [31:0] imem_load;
    logic        freeze;
    logic        halt;
    logic        branch_miss;
    logic [31:0] branch_correct_pc;
    logic        branch_resolved;
    logic [31:0] br_update_pc;
    logic        br_update_taken;
    logic [31:0] br_update_target;
    logic        out_valid;
    logic [31:0] out_imemload;
    logic [31:0] out_pc;
    logic [31:0] out_br_pc;
    logic        out_br_pred;

    modport master (
        output imem_ren, imem_addr, out_valid, out_imemload, out_pc, out_br_pc, out_br_pred,
        input  imem_hit, imem_load, freeze, halt, branch_miss, branch_correct_pc,
               branch_resolved, br_update_pc, br_update_taken, br_update_target
    );

    modport slave (
        input  imem_ren, imem_addr, out_valid, out_imemload, out_pc, out_br_pc, out_br_pred,
        output imem_hit, imem_load, freeze, halt, branch_miss, branch_correct_pc,
               branch_resolved, br_update_pc, br_update_taken, br_update_target
    );
endinterface

// File: rtl/fetch.sv
// fetch: PC register, imem request, direct-mapped 2-bit-counter BTB and the fetch/dispatch output register
module fetch #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BTB_ENTRIES = 16
) (
    input logic   CLK,
    input logic   nRST,
    fetch_if.master fif
);
    localparam int IDX = $clog2(BTB_ENTRIES);
    localparam int TW  = 30 - IDX;

    typedef enum logic {FETCH, HALTED} state_t;

    state_t state, next_state;
    logic [31:0] pc, next_pc;
    logic        next_valid, load;

    logic          btb_valid  [BTB_ENTRIES];
    logic [TW-1:0] btb_tag    [BTB_ENTRIES];
    logic [31:0]   btb_target [BTB_ENTRIES];
    logic [1:0]    btb_cnt    [BTB_ENTRIES];

    logic [IDX-1:0] idx, u_idx;
    logic [TW-1:0]  tag, u_tag;
    logic           pred, u_hit;
    logic [31:0]    npc;

    assign idx   = pc[IDX+1:2];
    assign tag   = pc[31:IDX+2];
    assign pred  = btb_valid[idx] && btb_tag[idx] == tag && btb_cnt[idx][1];
    assign npc   = pred ? btb_target[idx] : pc + 32'd4;
    assign u_idx = fif.br_update_pc[IDX+1:2];
    assign u_tag = fif.br_update_pc[31:IDX+2];
    assign u_hit = btb_valid[u_idx] && btb_tag[u_idx] == u_tag;

    assign fif.imem_ren  = state == FETCH;
    assign fif.imem_addr = pc;

    // Redirect beats halt beats accept; a hit that cannot be accepted is dropped and re-requested
    always_comb begin
        next_state = state;
        next_pc    = pc;
        next_valid = fif.out_valid;
        load       = 1'b0;
        if (fif.branch_miss) begin
            next_state = FETCH;
            next_pc    = {fif.branch_correct_pc[31:2], 2'b00};
            next_valid = 1'b0;
        end else if (fif.halt || state == HALTED) begin
            next_state = HALTED;
            next_valid = 1'b0;
        end else if (fif.imem_hit && (!fif.out_valid || !fif.freeze)) begin
            load       = 1'b1;
            next_pc    = npc;
            next_valid = 1'b1;
        end else if (!fif.freeze) begin
            next_valid = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state            <= FETCH;
            pc               <= RESET_PC;
            fif.out_valid    <= 1'b0;
            fif.out_imemload <= '0;
            fif.out_pc       <= '0;
            fif.out_br_pc    <= '0;
            fif.out_br_pred  <= 1'b0;
        end else begin
            state         <= next_state;
            pc            <= next_pc;
            fif.out_valid <= next_valid;
            if (load) begin
                fif.out_imemload <= fif.imem_load;
                fif.out_pc       <= pc;
                fif.out_br_pc    <= npc;
                fif.out_br_pred  <= pred;
            end
        end
    end

    // Training writes land at the edge, so a same-cycle lookup still sees the old entry
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_valid[i]  <= 1'b0;
                btb_tag[i]    <= '0;
                btb_target[i] <= '0;
                btb_cnt[i]    <= 2'b00;
            end
        end else if (fif.branch_resolved) begin
            if (u_hit) begin
                btb_cnt[u_idx] <= fif.br_update_taken
                    ? (btb_cnt[u_idx] == 2'b11 ? 2'b11 : btb_cnt[u_idx] + 2'd1)
                    : (btb_cnt[u_idx] == 2'b00 ? 2'b00 : btb_cnt[u_idx] - 2'd1);
                if (fif.br_update_taken)
                    btb_target[u_idx] <= fif.br_update_target;
            end else if (fif.br_update_taken) begin
                btb_valid[u_idx]  <= 1'b1;
                btb_tag[u_idx]    <= u_tag;
                btb_target[u_idx] <= fif.br_update_target;
                btb_cnt[u_idx]    <= 2'b10;
            end
        end
    end
endmodule

// File: tb/tb_fetch.sv
// tb_fetch: directed checks of fetch sequencing, freeze, BTB prediction/training, redirect, halt and reset
module tb_fetch;
    logic CLK = 1'b0;
    logic nRST;
    logic mem_on;
    int   n_chk = 0;
    int   n_fail = 0;

    fetch_if fif ();

    fetch #(.RESET_PC(32'h0), .BTB_ENTRIES(16)) dut (.CLK(CLK), .nRST(nRST), .fif(fif));

    always #5 CLK = ~CLK;

    // always-hit memory returns the fetch address as the instruction word
    assign fif.imem_hit  = mem_on;
    assign fif.imem_load = fif.imem_addr;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] p,
                           input logic [31:0] bp, input logic bpred);
        chk({tag, "_valid"}, {31'b0, fif.out_valid}, {31'b0, v});
        chk({tag, "_pc"}, fif.out_pc, p);
        chk({tag, "_load"}, fif.out_imemload, p);
        chk({tag, "_brpc"}, fif.out_br_pc, bp);
        chk({tag, "_pred"}, {31'b0, fif.out_br_pred}, {31'b0, bpred});
    endtask

    initial begin
        nRST = 1'b0;
        mem_on = 1'b0;
        fif.freeze = 1'b0;
        fif.halt = 1'b0;
        fif.branch_miss = 1'b0;
        fif.branch_correct_pc = '0;
        fif.branch_resolved = 1'b0;
        fif.br_update_pc = '0;
        fif.br_update_taken = 1'b0;
        fif.br_update_target = '0;
        #2;
        chk_out("rst", 1'b0, 32'h0, 32'h0, 1'b0);
        chk("rst_ren", {31'b0, fif.imem_ren}, 32'h1);
        chk("rst_addr", fif.imem_addr, 32'h0);
        #5;
        nRST = 1'b1;
        mem_on = 1'b1;
        step();
        chk_out("seq0", 1'b1, 32'h0, 32'h4, 1'b0);
        fif.branch_resolved = 1'b1;
        fif.br_update_pc = 32'h10;
        fif.br_update_taken = 1'b1;
        fif.br_update_target = 32'h40;
        step();
        chk_out("seq4", 1'b1, 32'h4, 32'h8, 1'b0);
        fif.branch_resolved = 1'b0;
        step();
        chk_out("seq8", 1'b1, 32'h8, 32'hC, 1'b0);
        fif.freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out("frz", 1'b1, 32'h8, 32'hC, 1'b0);
            chk("frz_addr", fif.imem_addr, 32'hC);
        end
        fif.freeze = 1'b0;
        step();
        chk_out("unfrz", 1'b1, 32'hC, 32'h10, 1'b0);
        step();
        chk_out("btb_taken", 1'b1, 32'h10, 32'h40, 1'b1);
        fif.branch_resolved = 1'b1;
        fif.br_update_pc = 32'h10;
        fif.br_update_taken = 1'b0;
        step();
        chk_out("btb_tgt", 1'b1, 32'h40, 32'h44, 1'b0);
        step();
        fif.branch_resolved = 1'b0;
        fif.branch_miss = 1'b1;
        fif.branch_correct_pc = 32'h12;
        step();
        fif.branch_miss = 1'b0;
        chk("mis_valid", {31'b0, fif.out_valid}, 32'h0);
        chk("mis_align", fif.imem_addr, 32'h10);
        step();
        chk_out("btb_nt", 1'b1, 32'h10, 32'h14, 1'b0);
        fif.freeze = 1'b1;
        fif.branch_miss = 1'b1;
        fif.branch_correct_pc = 32'h100;
        step();
        fif.branch_miss = 1'b0;
        chk("miss_drop", {31'b0, fif.out_valid}, 32'h0);
        chk("miss_addr", fif.imem_addr, 32'h100);
        step();
        chk_out("frz_empty", 1'b1, 32'h100, 32'h104, 1'b0);
        fif.freeze = 1'b0;
        mem_on = 1'b0;
        step();
        chk("bubble", {31'b0, fif.out_valid}, 32'h0);
        chk("bubble_addr", fif.imem_addr, 32'h104);
        mem_on = 1'b1;
        fif.halt = 1'b1;
        step();
        fif.halt = 1'b0;
        chk("halt_ren", {31'b0, fif.imem_ren}, 32'h0);
        chk("halt_valid", {31'b0, fif.out_valid}, 32'h0);
        step();
        chk("halted_ren", {31'b0, fif.imem_ren}, 32'h0);
        chk("halted_valid", {31'b0, fif.out_valid}, 32'h0);
        chk("halted_addr", fif.imem_addr, 32'h104);
        fif.branch_miss = 1'b1;
        fif.branch_correct_pc = 32'h20;
        step();
        fif.branch_miss = 1'b0;
        chk("resume_ren", {31'b0, fif.imem_ren}, 32'h1);
        chk("resume_addr", fif.imem_addr, 32'h20);
        step();
        chk_out("resume", 1'b1, 32'h20, 32'h24, 1'b0);
        fif.freeze = 1'b1;
        #2;
        nRST = 1'b0;
        #1;
        chk_out("async_rst", 1'b0, 32'h0, 32'h0, 1'b0);
        chk("async_rst_addr", fif.imem_addr, 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
